// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder: one digit per cycle, LSD first, with operand validity check.
// Define BCD_SUB_EN to add a SUB input that nines-complements B for decimal subtraction.
module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
`ifdef BCD_SUB_EN
  input  logic                sub,
`endif
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] z,
  output logic                cout,
  output logic                err
);

  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, ADD, FIN} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [4*DIGITS-1:0] a_q, b_q;
  logic                carry, sub_q, sub_in;
  logic                invalid;
  logic [3:0]          a_d, b_d, z_d;
  logic [4:0]          sum;
  logic                carry_n;

`ifdef BCD_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif

  always_comb begin
    invalid = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) invalid = 1'b1;
  end

  // Operands shift right each ADD cycle so the current digit is always at [3:0].
  always_comb begin
    a_d     = a_q[3:0];
    b_d     = sub_q ? 4'd9 - b_q[3:0] : b_q[3:0];
    sum     = {1'b0, a_d} + {1'b0, b_d} + {4'd0, carry};
    carry_n = (sum > 5'd9);
    z_d     = carry_n ? sum[3:0] + 4'd6 : sum[3:0];
  end

  // done is set on leaving FIN, so the DONE cycle sits in IDLE with busy still high;
  // start is ignored during that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      z     <= '0;
      cout  <= 1'b0;
      err   <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      sub_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (done) begin
            busy <= 1'b0;
          end else if (start) begin
            busy  <= 1'b1;
            a_q   <= a;
            b_q   <= b;
            carry <= cin;
            sub_q <= sub_in;
            cnt   <= '0;
            z     <= '0;
            cout  <= 1'b0;
            err   <= invalid;
            state <= invalid ? FIN : ADD;
          end
        end
        ADD: begin
          z[4*int'(cnt) +: 4] <= z_d;
          carry <= carry_n;
          a_q   <= a_q >> 4;
          b_q   <= b_q >> 4;
          if (cnt == LAST) begin
            cout  <= carry_n;
            cnt   <= '0;
            state <= FIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIN: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed bench for bcd_serial_adder (DIGITS=4): vector table plus reset/busy/done-cycle sequences.
module tb_bcd_serial_adder;
  localparam int DIGITS = 4;

  logic        clk = 1'b0;
  logic        reset, start, cin;
  logic [15:0] a, b;
`ifdef BCD_SUB_EN
  logic        sub;
`endif
  logic        busy, done, cout, err;
  logic [15:0] z;

  int n_chk = 0;
  int n_err = 0;

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .cin(cin),
`ifdef BCD_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .z(z), .cout(cout), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a, b;
    logic        cin, sub;
    logic [15:0] z;
    logic        cout, err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Pulse start for one cycle, scramble inputs after capture, wait (bounded) for done.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tcin,
                        input logic tsub, output logic [15:0] oz, output logic oc,
                        output logic oe, output int lat);
    @(negedge clk);
    a = ta; b = tb_v; cin = tcin; start = 1'b1;
`ifdef BCD_SUB_EN
    sub = tsub;
`else
    if (tsub) $display("note: subtract vector run without subtract support");
`endif
    @(negedge clk);
    start = 1'b0; a = 16'h9999; b = 16'h8888; cin = ~tcin;
`ifdef BCD_SUB_EN
    sub = ~tsub;
`endif
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    oz = z; oc = cout; oe = err;
  endtask

  logic [15:0] rz;
  logic        rc, re;
  int          lat;

  initial begin
    vecs.push_back('{16'h0001, 16'h0007, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b0});
    vecs.push_back('{16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{16'h0905, 16'h0095, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0});
    vecs.push_back('{16'h00A3, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1});
    vecs.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0});
    vecs.push_back('{16'h9999, 16'h9999, 1'b1, 1'b0, 16'h9999, 1'b1, 1'b0});
    vecs.push_back('{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0});
    vecs.push_back('{16'h5000, 16'h5000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{16'h0001, 16'hF000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1});
    vecs.push_back('{16'h0458, 16'h0567, 1'b0, 1'b0, 16'h1025, 1'b0, 1'b0});
`ifdef BCD_SUB_EN
    vecs.push_back('{16'h0500, 16'h0123, 1'b1, 1'b1, 16'h0377, 1'b1, 1'b0});
    vecs.push_back('{16'h0100, 16'h0200, 1'b1, 1'b1, 16'h9900, 1'b0, 1'b0});
    vecs.push_back('{16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0});
`endif

    reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef BCD_SUB_EN
    sub = 1'b0;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset z", z, 0);
    chk("reset cout", cout, 0);
    chk("reset err", err, 0);

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, rz, rc, re, lat);
      chk($sformatf("vec%0d latency", i), lat, vecs[i].err ? 1 : DIGITS + 1);
      chk($sformatf("vec%0d z", i), rz, vecs[i].z);
      chk($sformatf("vec%0d cout", i), rc, vecs[i].cout);
      chk($sformatf("vec%0d err", i), re, vecs[i].err);
    end

    // Busy timing, progressive digit write, start while busy, start in done cycle.
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy after capture", busy, 1);
    @(negedge clk);
    chk("digit0 written", z, 16'h0005);
    a = 16'h9999; b = 16'h9999; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 2;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("busy-start latency", lat, DIGITS + 1);
    chk("busy-start z", z, 16'h5555);
    chk("busy-start cout", cout, 0);
    chk("busy in done cycle", busy, 1);
    start = 1'b1; a = 16'h0001; b = 16'h0001; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("done-cycle start ignored busy", busy, 0);
    chk("done pulse one cycle", done, 0);
    chk("done-cycle start ignored z", z, 16'h5555);

    // Reset during second ADD cycle.
    @(negedge clk);
    a = 16'h9999; b = 16'h0001; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid reset busy", busy, 0);
    chk("mid reset z", z, 0);
    chk("mid reset cout", cout, 0);
    begin
      int seen = 0;
      repeat (8) begin
        @(negedge clk);
        if (done) seen++;
      end
      chk("no done after reset", seen, 0);
    end
    run_op(16'h0905, 16'h0095, 1'b1, 1'b0, rz, rc, re, lat);
    chk("post-reset latency", lat, DIGITS + 1);
    chk("post-reset z", rz, 16'h1001);

    // Reset dominates start on the same edge.
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; start = 1'b1; a = 16'h0001; b = 16'h0002;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk("reset over start busy", busy, 0);
    chk("reset over start z", z, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
